axi_sram_bridge_mp: RTL and testbench
=====================================

Name: axi_sram_bridge_mp

Overview:
- Parametrised SRAM-like-to-AXI3 bridge. Serves NPORT SRAM-like masters (port 0 = inst, port 1 = data, higher ports = future DMA/cache refill) over one AXI master interface.
- Adds four capabilities:
  - fixed-priority arbitration across N ports;
  - up to OST outstanding reads per port, with out-of-order return across ports;
  - independent AW/W handshakes;
  - word-address read-after-write hazard blocking.

Parameters:
- NPORT, 2, number of SRAM-like ports (1..8); the port index is the AXI ID.
- OST, 2, max outstanding reads per port (1..4).
- ID_W, 4, AXI ID width; must satisfy NPORT <= 2**ID_W.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- s_req  in  NPORT  per-port request.
- s_wr  in  NPORT  per-port 1 = write.
- s_size  in  2*NPORT  per-port size: 0 = 1B, 1 = 2B, 2 = 4B.
- s_wstrb  in  4*NPORT  per-port byte enables.
- s_addr  in  32*NPORT  per-port address.
- s_wdata  in  32*NPORT  per-port write data.
- s_addr_ok  out  NPORT  request accepted.
- s_data_ok  out  NPORT  read data valid or write complete (one-cycle pulse).
- s_rdata  out  32*NPORT  read data; valid when s_data_ok is high.
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  ID_W/32/8/3/2/2/4/3/1  AXI read address channel.
- arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  ID_W/32/2/1/1  AXI read data channel.
- rready  out  1
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  same widths as AR.
- awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  ID_W/32/4/1/1  AXI write data channel.
- wready  in  1
- bid/bresp/bvalid  in  ID_W/2/1  AXI write response channel.
- bready  out  1

Behaviour:
- Constant outputs:
  - arlen = awlen = 0;
  - arburst = awburst = 2'b01;
  - lock/cache/prot = 0;
  - wlast = 1;
  - wid = awid.
- Reset values:
  - all valids, s_addr_ok, s_data_ok, ost counters = 0;
  - AR/AW/W payload registers and s_rdata = 0.
- Read arbitration, combinational, every cycle:
  - Eligible port p: s_req[p] & ~s_wr[p] & ost_cnt[p] < OST & not hazard-blocked.
  - Grant goes to the highest eligible index.
- AR slot states, two states:
  - AR_IDLE: on a grant, pulse s_addr_ok[p] in the same cycle. Latch arid = p, araddr, arsize = {1'b0, s_size[p]}. Move to AR_BUSY.
  - AR_BUSY: arvalid = 1 and the payload is held stable. On arready, return to AR_IDLE. No new grant is given in the handshake cycle, so the minimum spacing is 2 cycles.
- ost_cnt[p]:
  - increments on read s_addr_ok[p];
  - decrements on read s_data_ok[p];
  - is unchanged when both happen in the same cycle.
- Read response path:
  - rready = 1 whenever any ost_cnt is non-zero.
  - On rvalid & rready with rid = k < NPORT: next cycle s_rdata[k] = rdata and s_data_ok[k] pulses.
  - rid >= NPORT is consumed with no effect.
  - Per-port order is preserved, because all requests from one port share one ID.
- Write arbitration, same highest-index rule:
  - Eligible port p: s_req[p] & s_wr[p], and no write is pending.
  - Only one write is outstanding at a time.
- Write state machine:
  - W_IDLE: on a grant, pulse s_addr_ok[p]. Latch awid = p, awaddr, awsize, wdata, wstrb. Go to W_SEND with awvalid = wvalid = 1.
  - W_SEND: each valid drops after its own handshake. The AW and W handshakes may happen in either order or in the same cycle. When both are done, go to W_RESP.
  - W_RESP: bready = 1. On bvalid, pulse s_data_ok[awid] in the next cycle and return to W_IDLE.
- Write pending: asserted from the write grant until the B handshake cycle, inclusive.
- RAW hazard:
  - A read from any port is blocked while a write is pending with awaddr[31:2] == s_addr[p][31:2].
  - A read is also blocked when a write with an equal word address is granted in the same cycle.
  - A blocked read receives no addr_ok and must stay asserted by the master.
- Concurrency:
  - A read grant and a write grant to different ports may occur in the same cycle.
  - Read and write data_ok pulses to the same port cannot collide, because SRAM-like masters wait for data_ok.
- Reset mid-operation:
  - All state clears in the cycle after aresetn is sampled low.
  - In-flight responses are dropped and no data_ok pulses.

Test Plan:
- Concurrent reads: port0 and port1 read together at 0x1000 and 0x2000 → port1 receives addr_ok first, then port0 two cycles later. arid = 1 then 0. Respond rid = 0 first, then 1 → data_ok[0] then data_ok[1] with the correct rdata.
- Outstanding limit: port0 issues 3 back-to-back reads with OST = 2 and R held off → exactly 2 addr_ok, then the third stalls. One R beat → the third is accepted the cycle after data_ok[0].
- Split write handshakes: port1 writes 0xDEADBEEF to 0x80, wstrb = 0xF, awready delayed 3 cycles after wready → B is issued only after both handshakes. data_ok[1] arrives 1 cycle after bvalid & bready.
- RAW blocking: write to 0x84 pending, then a read of 0x86 (same word) → no addr_ok until B completes. A read of 0x88 in the same window is accepted immediately.
- Size mapping: byte read with size 0 → arsize = 0; halfword with size 1 → arsize = 1. A bad rid = 7 beat is consumed with no data_ok.
- Reset during W_SEND → the next cycle has awvalid = wvalid = bready = 0, all ost_cnt = 0, and no s_data_ok.

Source files
------------

// File: rtl/axi_sram_bridge_mp.sv
`default_nettype none
// ============================================================================
// axi_sram_bridge_mp : NPORT SRAM-like masters onto one AXI3 master port  rev 1.0
// ============================================================================
module axi_sram_bridge_mp #(
  parameter int NPORT = 2,
  parameter int OST   = 2,
  parameter int ID_W  = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [NPORT-1:0]      s_req,
  input  logic [NPORT-1:0]      s_wr,
  input  logic [2*NPORT-1:0]    s_size,
  input  logic [4*NPORT-1:0]    s_wstrb,
  input  logic [32*NPORT-1:0]   s_addr,
  input  logic [32*NPORT-1:0]   s_wdata,
  output logic [NPORT-1:0]      s_addr_ok,
  output logic [NPORT-1:0]      s_data_ok,
  output logic [32*NPORT-1:0]   s_rdata,
  output logic [ID_W-1:0]       arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [ID_W-1:0]       rid,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ID_W-1:0]       awid,
  output logic [31:0]           awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ID_W-1:0]       wid,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [ID_W-1:0]       bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int CNT_W = $clog2(OST + 1);

  typedef enum logic [0:0] {AR_IDLE = 1'b0, AR_BUSY = 1'b1} ar_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_SEND = 2'd1, W_RESP = 2'd2} w_state_t;

  ar_state_t ar_state, ar_next;
  w_state_t  w_state, w_next;

  logic [31:0]      addr_a  [NPORT];
  logic [1:0]       size_a  [NPORT];
  logic [31:0]      wdata_a [NPORT];
  logic [3:0]       wstrb_a [NPORT];
  logic [31:0]      rdata_q [NPORT];
  logic [CNT_W-1:0] ost_cnt [NPORT];

  logic [NPORT-1:0] rd_elig, wr_elig, rd_inc, rd_ok, wr_ok, ost_busy;
  logic             rd_gnt, wr_gnt, wr_pend, rsp_fire;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [31:0]      rd_addr, wr_addr, wr_data;
  logic [1:0]       rd_size, wr_size;
  logic [3:0]       wr_strb;
  logic             unused_ok;

  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wlast   = 1'b1;
  assign wid     = awid;

  assign wr_pend   = (w_state != W_IDLE);
  assign rready    = |ost_busy;
  assign rsp_fire  = rvalid && rready;
  assign unused_ok = ^{rresp, rlast, bid, bresp};

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    logic raw_block;
    assign addr_a[p]  = s_addr[32*p +: 32];
    assign size_a[p]  = s_size[2*p +: 2];
    assign wdata_a[p] = s_wdata[32*p +: 32];
    assign wstrb_a[p] = s_wstrb[4*p +: 4];
    assign s_rdata[32*p +: 32] = rdata_q[p];
    assign ost_busy[p] = (ost_cnt[p] != '0);
    // A pending write or one granted this very cycle hides the word from reads
    assign raw_block = (wr_pend && (awaddr[31:2] == addr_a[p][31:2])) ||
                       (wr_gnt && (wr_addr[31:2] == addr_a[p][31:2]));
    assign rd_elig[p] = aresetn && (ar_state == AR_IDLE) && s_req[p] && !s_wr[p] &&
                        (ost_cnt[p] < CNT_W'(OST)) && !raw_block;
    assign wr_elig[p] = aresetn && (w_state == W_IDLE) && s_req[p] && s_wr[p];
    assign rd_inc[p]    = rd_gnt && (rd_idx == IDX_W'(p));
    assign s_addr_ok[p] = rd_inc[p] || (wr_gnt && (wr_idx == IDX_W'(p)));
    assign s_data_ok[p] = rd_ok[p] | wr_ok[p];
  end

  // Highest index wins: later loop iterations overwrite earlier ones
  always_comb begin
    wr_gnt  = 1'b0;
    wr_idx  = '0;
    wr_addr = '0;
    wr_size = '0;
    wr_data = '0;
    wr_strb = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (wr_elig[p]) begin
        wr_gnt  = 1'b1;
        wr_idx  = IDX_W'(p);
        wr_addr = addr_a[p];
        wr_size = size_a[p];
        wr_data = wdata_a[p];
        wr_strb = wstrb_a[p];
      end
    end
  end

  always_comb begin
    rd_gnt  = 1'b0;
    rd_idx  = '0;
    rd_addr = '0;
    rd_size = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (rd_elig[p]) begin
        rd_gnt  = 1'b1;
        rd_idx  = IDX_W'(p);
        rd_addr = addr_a[p];
        rd_size = size_a[p];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ar_state <= AR_IDLE;
      w_state  <= W_IDLE;
    end else begin
      ar_state <= ar_next;
      w_state  <= w_next;
    end
  end

  always_comb begin
    ar_next = ar_state;
    arvalid = 1'b0;
    case (ar_state)
      AR_IDLE: if (rd_gnt) ar_next = AR_BUSY;
      AR_BUSY: begin
        arvalid = 1'b1;
        if (arready) ar_next = AR_IDLE;
      end
      default: ar_next = AR_IDLE;
    endcase
  end

  always_comb begin
    w_next = w_state;
    bready = 1'b0;
    case (w_state)
      W_IDLE: if (wr_gnt) w_next = W_SEND;
      W_SEND: if ((!awvalid || awready) && (!wvalid || wready)) w_next = W_RESP;
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      arid   <= '0;
      araddr <= '0;
      arsize <= '0;
    end else if (rd_gnt) begin
      arid   <= ID_W'(rd_idx);
      araddr <= rd_addr;
      arsize <= {1'b0, rd_size};
    end
  end

  // AW and W retire independently; each valid drops on its own handshake
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      awid    <= '0;
      awaddr  <= '0;
      awsize  <= '0;
      wdata   <= '0;
      wstrb   <= '0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
    end else if (wr_gnt) begin
      awid    <= ID_W'(wr_idx);
      awaddr  <= wr_addr;
      awsize  <= {1'b0, wr_size};
      wdata   <= wr_data;
      wstrb   <= wr_strb;
      awvalid <= 1'b1;
      wvalid  <= 1'b1;
    end else begin
      if (awvalid && awready) awvalid <= 1'b0;
      if (wvalid && wready)   wvalid  <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_ok <= '0;
      wr_ok <= '0;
      for (int p = 0; p < NPORT; p++) begin
        rdata_q[p] <= '0;
        ost_cnt[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        rd_ok[p] <= rsp_fire && (rid == ID_W'(p));
        wr_ok[p] <= bready && bvalid && (awid == ID_W'(p));
        if (rsp_fire && (rid == ID_W'(p))) rdata_q[p] <= rdata;
        if (rd_inc[p] && !rd_ok[p])
          ost_cnt[p] <= ost_cnt[p] + 1'b1;
        else if (rd_ok[p] && !rd_inc[p] && ost_busy[p])
          ost_cnt[p] <= ost_cnt[p] - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_bridge_mp.sv
`default_nettype none
// ============================================================================
// tb_axi_sram_bridge_mp : directed self-checking bench for axi_sram_bridge_mp  rev 1.0
// ============================================================================
module tb_axi_sram_bridge_mp;
  localparam int NP   = 3;
  localparam int ID_W = 4;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic [NP-1:0]    s_req, s_wr, s_addr_ok, s_data_ok;
  logic [2*NP-1:0]  s_size;
  logic [4*NP-1:0]  s_wstrb;
  logic [32*NP-1:0] s_addr, s_wdata, s_rdata;
  logic [ID_W-1:0]  arid, rid, awid, wid, bid;
  logic [31:0]      araddr, rdata, awaddr, wdata;
  logic [7:0]       arlen, awlen;
  logic [2:0]       arsize, arprot, awsize, awprot;
  logic [1:0]       arburst, arlock, awburst, awlock, rresp, bresp;
  logic [3:0]       arcache, awcache, wstrb;
  logic             arvalid, arready, rlast, rvalid, rready;
  logic             awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int n_pass  = 0;
  int n_total = 0;

  always #5 aclk = ~aclk;

  axi_sram_bridge_mp #(.NPORT(NP), .OST(2), .ID_W(ID_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_port(input int p, input logic req, input logic wr,
                          input logic [1:0] size, input logic [31:0] addr);
    s_req[p] = req;
    s_wr[p]  = wr;
    s_size[2*p +: 2]  = size;
    s_addr[32*p +: 32] = addr;
  endtask

  initial begin
    aresetn = 1'b0;
    s_req = '0; s_wr = '0; s_size = '0; s_wstrb = '0; s_addr = '0; s_wdata = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;

    repeat (3) cyc();
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_rready", rready, 0);
    check("rst_data_ok", s_data_ok, 0);
    check("rst_rdata", s_rdata[63:0], 0);
    check("rst_araddr", araddr, 0);
    check("const_arburst", arburst, 2'b01);
    check("const_wlast", wlast, 1);
    check("const_arlen", arlen, 0);

    // Concurrent reads: port1 wins, port0 two cycles later, out-of-order return
    aresetn = 1'b1;
    set_port(0, 1, 0, 2'd2, 32'h1000);
    set_port(1, 1, 0, 2'd2, 32'h2000);
    #1 check("cr_aok_p1", s_addr_ok, 3'b010);
    cyc(); set_port(1, 0, 0, 2'd2, 32'h2000);
    #1 check("cr_arvalid1", arvalid, 1);
    check("cr_arid1", arid, 1);
    check("cr_araddr1", araddr, 32'h2000);
    check("cr_arsize1", arsize, 2);
    check("cr_aok_busy", s_addr_ok, 0);
    arready = 1'b1;
    #1 check("cr_aok_hs", s_addr_ok, 0);
    cyc(); arready = 1'b0;
    #1 check("cr_aok_p0", s_addr_ok, 3'b001);
    cyc(); s_req[0] = 1'b0; arready = 1'b1;
    #1 check("cr_arid0", arid, 0);
    check("cr_araddr0", araddr, 32'h1000);
    cyc(); arready = 1'b0;
    #1 check("cr_rready", rready, 1);
    rvalid = 1'b1; rid = 4'd0; rdata = 32'hAAAA0000;
    cyc(); rid = 4'd1; rdata = 32'hBBBB1111;
    #1 check("cr_dok0", s_data_ok, 3'b001);
    check("cr_rdata0", s_rdata[31:0], 32'hAAAA0000);
    cyc(); rvalid = 1'b0;
    #1 check("cr_dok1", s_data_ok, 3'b010);
    check("cr_rdata1", s_rdata[63:32], 32'hBBBB1111);
    cyc();
    #1 check("cr_dok_idle", s_data_ok, 0);
    check("cr_rready_idle", rready, 0);

    // Outstanding limit of 2 on port0
    set_port(0, 1, 0, 2'd2, 32'h3000);
    arready = 1'b1;
    #1 check("ost_aok1", s_addr_ok, 3'b001);
    cyc(); #1 check("ost_c1", s_addr_ok, 0);
    cyc(); #1 check("ost_aok2", s_addr_ok, 3'b001);
    cyc(); #1 check("ost_c3", s_addr_ok, 0);
    cyc(); #1 check("ost_stall4", s_addr_ok, 0);
    cyc(); #1 check("ost_stall5", s_addr_ok, 0);
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h55;
    cyc(); rvalid = 1'b0;
    #1 check("ost_dok", s_data_ok, 3'b001);
    check("ost_stall6", s_addr_ok, 0);
    cyc(); #1 check("ost_aok3", s_addr_ok, 3'b001);
    cyc(); s_req[0] = 1'b0;
    cyc(); arready = 1'b0; rvalid = 1'b1; rid = 4'd0;
    cyc();
    #1 check("ost_drain1", s_data_ok, 3'b001);
    cyc(); rvalid = 1'b0;
    #1 check("ost_drain2", s_data_ok, 3'b001);
    cyc(); #1 check("ost_rready0", rready, 0);

    // Split AW/W handshakes on port1
    set_port(1, 1, 1, 2'd2, 32'h80);
    s_wdata[63:32] = 32'hDEADBEEF; s_wstrb[7:4] = 4'hF;
    #1 check("wr_aok", s_addr_ok, 3'b010);
    cyc(); set_port(1, 0, 1, 2'd2, 32'h80);
    #1 check("wr_awvalid", awvalid, 1);
    check("wr_wvalid", wvalid, 1);
    check("wr_awaddr", awaddr, 32'h80);
    check("wr_awid", awid, 1);
    check("wr_wid", wid, 1);
    check("wr_wdata", wdata, 32'hDEADBEEF);
    check("wr_wstrb", wstrb, 4'hF);
    check("wr_awsize", awsize, 2);
    wready = 1'b1;
    cyc(); wready = 1'b0;
    #1 check("wr_wvalid_drop", wvalid, 0);
    check("wr_awvalid_hold", awvalid, 1);
    cyc(); #1 check("wr_bready_wait", bready, 0);
    cyc(); awready = 1'b1;
    #1 check("wr_bready_wait2", bready, 0);
    cyc(); awready = 1'b0;
    #1 check("wr_awvalid_drop", awvalid, 0);
    check("wr_bready", bready, 1);
    bvalid = 1'b1;
    cyc(); bvalid = 1'b0;
    #1 check("wr_dok", s_data_ok, 3'b010);
    check("wr_bready_off", bready, 0);
    cyc(); #1 check("wr_dok_off", s_data_ok, 0);

    // RAW hazard: write 0x84 pending blocks read 0x86, read 0x88 passes
    set_port(1, 1, 1, 2'd2, 32'h84);
    set_port(0, 1, 0, 2'd2, 32'h86);
    #1 check("raw_same_cycle", s_addr_ok, 3'b010);
    cyc(); s_req[1] = 1'b0; set_port(2, 1, 0, 2'd2, 32'h88);
    #1 check("raw_other_word", s_addr_ok, 3'b100);
    cyc(); s_req[2] = 1'b0; arready = 1'b1;
    #1 check("raw_busy", s_addr_ok, 0);
    cyc(); arready = 1'b0; awready = 1'b1; wready = 1'b1;
    #1 check("raw_blk_send", s_addr_ok, 0);
    cyc(); awready = 1'b0; wready = 1'b0;
    #1 check("raw_blk_resp", s_addr_ok, 0);
    check("raw_bready", bready, 1);
    bvalid = 1'b1;
    #1 check("raw_blk_bhs", s_addr_ok, 0);
    cyc(); bvalid = 1'b0;
    #1 check("raw_wr_dok", s_data_ok, 3'b010);
    check("raw_released", s_addr_ok, 3'b001);
    cyc(); s_req[0] = 1'b0; arready = 1'b1;
    cyc(); arready = 1'b0; rvalid = 1'b1; rid = 4'd2; rdata = 32'h22;
    cyc(); rid = 4'd0; rdata = 32'h11;
    #1 check("raw_dok2", s_data_ok, 3'b100);
    check("raw_rdata2", s_rdata[95:64], 32'h22);
    cyc(); rvalid = 1'b0;
    #1 check("raw_dok0", s_data_ok, 3'b001);
    check("raw_rdata0", s_rdata[31:0], 32'h11);
    cyc(); #1 check("raw_rready0", rready, 0);

    // Size mapping and an out-of-range rid
    set_port(0, 1, 0, 2'd0, 32'h101);
    #1 check("sz_aok_b", s_addr_ok, 3'b001);
    cyc(); s_req[0] = 1'b0; arready = 1'b1;
    #1 check("sz_arsize_b", arsize, 0);
    check("sz_araddr_b", araddr, 32'h101);
    cyc(); arready = 1'b0; set_port(0, 1, 0, 2'd1, 32'h202);
    #1 check("sz_aok_h", s_addr_ok, 3'b001);
    cyc(); s_req[0] = 1'b0; arready = 1'b1;
    #1 check("sz_arsize_h", arsize, 1);
    cyc(); arready = 1'b0; rvalid = 1'b1; rid = 4'd7; rdata = 32'hBAD;
    cyc(); rid = 4'd0; rdata = 32'hAB;
    #1 check("badrid_no_dok", s_data_ok, 0);
    cyc(); rdata = 32'hCDCD;
    #1 check("sz_dok1", s_data_ok, 3'b001);
    check("sz_rdata1", s_rdata[31:0], 32'hAB);
    cyc(); rvalid = 1'b0;
    #1 check("sz_dok2", s_data_ok, 3'b001);
    check("sz_rdata2", s_rdata[31:0], 32'hCDCD);
    cyc(); #1 check("sz_rready0", rready, 0);

    // Reset while the write is in W_SEND with a read in flight
    set_port(1, 1, 1, 2'd2, 32'h40);
    set_port(0, 1, 0, 2'd2, 32'h500);
    #1 check("rs_dual_grant", s_addr_ok, 3'b011);
    cyc(); s_req = '0; arready = 1'b1;
    #1 check("rs_awvalid_pre", awvalid, 1);
    cyc(); arready = 1'b0;
    #1 check("rs_rready_pre", rready, 1);
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h77; aresetn = 1'b0;
    cyc(); rvalid = 1'b0; aresetn = 1'b1;
    #1 check("rs_awvalid", awvalid, 0);
    check("rs_wvalid", wvalid, 0);
    check("rs_bready", bready, 0);
    check("rs_rready", rready, 0);
    check("rs_arvalid", arvalid, 0);
    check("rs_dok", s_data_ok, 0);
    cyc(); #1 check("rs_dok_after", s_data_ok, 0);
    check("rs_rdata", s_rdata[31:0], 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
